// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/shift/rotate/arith-shift/load, single-step or
// as an automatic multi-step burst of a latched operation.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] din,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      3'b001:  res = {sr, cur[WIDTH-1:1]};
      3'b010:  res = {cur[WIDTH-2:0], sl};
      3'b011:  res = {cur[0], cur[WIDTH-1:1]};
      3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      3'b110:  res = ld;
      default: res = cur;
    endcase
    return res;
  endfunction

  logic burst_ok;
  assign burst_ok = burst_start && (burst_len != '0) && (mode inside {[3'd1:3'd5]});

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (burst_ok) begin
          // First burst step happens on the accepting edge, so a length-1
          // burst never enters BURST and signals done straight away.
          q_d    = step_op(mode, q_q, sin_r, sin_l, din);
          mode_d = mode;
          rem_d  = burst_len - CNT_W'(1);
          if (burst_len == CNT_W'(1)) begin
            done_d = 1'b1;
          end else begin
            state_d = BURST;
          end
        end else if (en) begin
          q_d = step_op(mode, q_q, sin_r, sin_l, din);
        end
      end
      BURST: begin
        q_d   = step_op(mode_q, q_q, sin_r, sin_l, din);
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      q_q     <= '0;
      mode_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign busy   = (state_q == BURST);
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed scenarios plus randomized traffic,
// all checked against an arithmetic reference model.
module tb_universal_shift_reg;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          clr, en, sin_r, sin_l, burst_start;
  logic [2:0]    mode;
  logic [W-1:0]  din;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  q;
  logic          sout_r, sout_l, busy, done;

  universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .din(din), .burst_start(burst_start), .burst_len(burst_len),
    .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: value as an integer, burst as a count of steps left.
  int unsigned m_q;
  int unsigned m_left;
  int unsigned m_mode;
  bit          m_done;

  function automatic int unsigned apply_op(input int unsigned op, input int unsigned v,
                                           input int unsigned sr, input int unsigned sl,
                                           input int unsigned ld);
    int unsigned msb_w;
    msb_w = 1 << (W - 1);
    case (op)
      1: return (v >> 1) + sr * msb_w;
      2: return ((v * 2) % (1 << W)) + sl;
      3: return (v >> 1) + (v % 2) * msb_w;
      4: return ((v * 2) % (1 << W)) + (v / msb_w);
      5: return (v >> 1) + (v & msb_w);
      6: return ld;
      default: return v;
    endcase
  endfunction

  task automatic model_edge();
    if (clr) begin
      m_q = 0; m_left = 0; m_mode = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_q    = apply_op(m_mode, m_q, sin_r, sin_l, din);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else if (burst_start && burst_len != 0 && mode >= 1 && mode <= 5) begin
      m_mode = mode;
      m_q    = apply_op(m_mode, m_q, sin_r, sin_l, din);
      m_left = burst_len - 1;
      m_done = (m_left == 0);
    end else begin
      if (en) m_q = apply_op(mode, m_q, sin_r, sin_l, din);
      m_done = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("q", q, m_q);
    check("busy", busy, m_left > 0);
    check("done", done, m_done);
    check("sout_r", sout_r, m_q % 2);
    check("sout_l", sout_l, m_q >> (W - 1));
  endtask

  task automatic load(input logic [W-1:0] v);
    burst_start = 0; mode = 3'b110; en = 1; din = v;
    tick();
  endtask

  initial begin
    clr = 1; en = 1; mode = 3'b110; din = 8'hFF; sin_r = 0; sin_l = 0;
    burst_start = 0; burst_len = 0;
    m_q = 0; m_left = 0; m_mode = 0; m_done = 0;
    tick();
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    clr = 0;

    load(8'hA5);
    check("load_a5", q, 8'hA5);
    mode = 3'b001; sin_r = 0; en = 1; tick();
    check("shr", q, 8'h52);
    check("shr_sout_r", sout_r, 1'b0);
    en = 0; tick();
    check("shr_en0", q, 8'h52);

    load(8'h81); mode = 3'b100; tick(); check("rol", q, 8'h03);
    load(8'h80); mode = 3'b101; tick(); check("asr", q, 8'hC0);
    load(8'h01); mode = 3'b010; sin_l = 1; tick(); check("shl", q, 8'h03);

    // ROR burst of 3 with mode/en disturbed mid-burst
    load(8'h01);
    mode = 3'b011; burst_len = 3; burst_start = 1; en = 0; tick();
    check("b1_q", q, 8'h80); check("b1_busy", busy, 1'b1); check("b1_done", done, 1'b0);
    burst_start = 0; mode = 3'b110; en = 1; din = 8'h3C; tick();
    check("b2_q", q, 8'h40); check("b2_busy", busy, 1'b1);
    tick();
    check("b3_q", q, 8'h20); check("b3_busy", busy, 1'b0); check("b3_done", done, 1'b1);
    en = 0; tick();
    check("b4_done", done, 1'b0); check("b4_q", q, 8'h20);

    // ignored burst requests
    mode = 3'b001; burst_len = 0; burst_start = 1; en = 0; tick();
    check("len0_q", q, 8'h20); check("len0_busy", busy, 1'b0); check("len0_done", done, 1'b0);
    mode = 3'b110; burst_len = 3; din = 8'hEE; tick();
    check("ld_burst_q", q, 8'h20); check("ld_burst_busy", busy, 1'b0);
    tick(); check("ld_burst_done", done, 1'b0);

    // length-1 burst, then back-to-back burst accepted while done is high
    mode = 3'b001; sin_r = 1; burst_len = 1; burst_start = 1; tick();
    check("len1_busy", busy, 1'b0); check("len1_done", done, 1'b1);
    burst_len = 2; tick();
    check("b2b_busy", busy, 1'b1);
    burst_start = 0; tick();
    check("b2b_done", done, 1'b1);

    // aborted burst
    load(8'hFF);
    mode = 3'b001; sin_r = 0; burst_len = 5; burst_start = 1; tick();
    burst_start = 0; tick();
    check("abort_pre", q, 8'h3F);
    clr = 1; tick();
    check("abort_q", q, 8'h00); check("abort_busy", busy, 1'b0);
    clr = 0; en = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); check("abort_done", done, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clr         = ($urandom_range(0, 99) == 0);
      en          = $urandom_range(0, 1);
      mode        = 3'($urandom_range(0, 7));
      sin_r       = $urandom_range(0, 1);
      sin_l       = $urandom_range(0, 1);
      din         = 8'($urandom);
      burst_start = ($urandom_range(0, 3) == 0);
      burst_len   = 4'($urandom_range(0, 9));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter CNT_W, default 4, burst length counter width; 2**CNT_W-1 >= WIDTH is required.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, single-step enable for non-burst operation.
REQ-006 SHALL have port mode, input, 3, operation select.
REQ-007 SHALL have port sin_r, input, 1, serial input entering at MSB on right shift.
REQ-008 SHALL have port sin_l, input, 1, serial input entering at LSB on left shift.
REQ-009 SHALL have port din, input, WIDTH, parallel load data.
REQ-010 SHALL have port burst_start, input, 1, request an automatic multi-step shift.
REQ-011 SHALL have port burst_len, input, CNT_W, number of steps in a burst.
REQ-012 SHALL have port q, output, WIDTH, register contents.
REQ-013 SHALL have port sout_r, output, 1, equal to q[0], combinational from q.
REQ-014 SHALL have port sout_l, output, 1, equal to q[WIDTH-1], combinational from q.
REQ-015 SHALL have port busy, output, 1, high while a burst has steps remaining after the current edge.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after the final burst step.

Function
REQ-017 SHALL decode mode as:
- 000: hold
- 001: SHR, q <= {sin_r, q[W-1:1]}
- 010: SHL, q <= {q[W-2:0], sin_l}
- 011: ROR, q <= {q[0], q[W-1:1]}
- 100: ROL, q <= {q[W-2:0], q[W-1]}
- 101: ASR, q <= {q[W-1], q[W-1:1]}
- 110: parallel load, q <= din
- 111: hold
REQ-018 SHALL implement a two-state FSM, IDLE and BURST, resetting to IDLE.
REQ-019 SHALL, in IDLE with burst_start=0, apply the mode operation on an edge only when en=1, and hold q otherwise.
REQ-020 SHALL, in IDLE with burst_start=1, burst_len!=0 and mode in {001..101}, perform the first step on that same edge (regardless of en), latch mode, and load remaining = burst_len-1.
REQ-021 SHALL treat burst_start with burst_len=0, or with mode in {000,110,111}, as if burst_start were 0; no busy, no done.
REQ-022 SHALL, when burst_len=1, perform exactly one step, keep busy low, and assert done in the following cycle.
REQ-023 SHALL, when burst_len>1, enter BURST with busy=1; each subsequent edge performs one step of the latched mode and decrements remaining.
REQ-024 SHALL, in BURST, sample sin_r and sin_l live on every step.
REQ-025 SHALL, in BURST, ignore en, mode, din and burst_start.
REQ-026 SHALL, on the edge that performs the final step, return to IDLE, drop busy, and assert done for exactly one cycle.
REQ-027 SHALL complete a burst of length N in exactly N edges from the start edge; done is visible after edge N.
REQ-028 SHALL allow a new burst_start in the cycle done is high; it is accepted as in REQ-020.
REQ-029 SHALL keep done low in all cycles other than REQ-022/REQ-026.

Reset
REQ-030 SHALL, on clr=1 at an edge, set q=0, busy=0, done=0, state=IDLE, remaining=0, overriding all other inputs including an active burst.
REQ-031 SHALL NOT assert done on the edge after an aborted burst.

Verification (WIDTH=8)
REQ-032 SHALL cover: clr=1 for one edge with din=8'hFF, mode=110, en=1 -> q=8'h00, busy=0, done=0.
REQ-033 SHALL cover: load 8'hA5 (mode=110, en=1), then mode=001, sin_r=0, en=1 for one edge -> q=8'h52, sout_r=0; same with en=0 -> q unchanged.
REQ-034 SHALL cover: q=8'h81 with mode=100 for one edge -> 8'h03; q=8'h80 with mode=101 for one edge -> 8'hC0; q=8'h01 with mode=010, sin_l=1 -> 8'h03.
REQ-035 SHALL cover: q=8'h01, mode=011, burst_len=3, burst_start pulse -> q=8'h80, 8'h40, 8'h20 on three successive edges; busy high for 2 cycles; done high for 1 cycle after the third edge; mode changes mid-burst have no effect.
REQ-036 SHALL cover: burst_len=0, or mode=110 with burst_start=1 and en=0 -> q unchanged, busy=0, done=0.
REQ-037 SHALL cover: a burst of length 5 on 8'hFF with mode=001, sin_r=0 and clr=1 after the second edge -> q=8'h00, busy=0, and done stays low thereafter.
